sec32_encoder_pipe: RTL and testbench

Pipelined check-bit generator sitting directly upstream of the 32-bit single-error-correcting decoder. Accepts 32-bit data words over a valid/ready handshake, computes the 8 Hamming-style check bits the decoder's syndrome network expects, and presents `{data, check, enable}` to the storage/channel path feeding that decoder. Includes a one-shot error-injection facility so the downstream corrector can be exercised in-system, plus a wrapping count of emitted words.

---
 rtl/sec32_encoder_pipe.sv | 189 ++++++++++++++++++
 tb/tb_sec32_encoder_pipe.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sec32_encoder_pipe.sv
// Two-stage check-bit generator for the 32-bit SEC decoder, with one-shot
// error injection on the next accepted word and a wrapping output-word count.
module sec32_encoder_pipe #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   input  logic             chk_en,
   input  logic             inj_req,
   input  logic [39:0]      inj_mask,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic [7:0]       out_check,
   output logic             out_en,
   output logic             inj_done,
   output logic [CNT_W-1:0] word_count
);

   typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} inj_st_e;

   // Check bits touched by data bit k: the two 16-bit halves use mirrored
   // column patterns so every data bit maps to a distinct weight-3 syndrome.
   function automatic logic [7:0] col_of(input int k);
      logic [7:0] c;
      int         j;
      c = '0;
      j = k % 16;
      if (k < 16) begin
         c = c | (8'b1 << (j % 4));
         c = c | (8'b1 << ((j < 8) ? 4 : 5));
         c = c | (8'b1 << (((j % 8) < 4) ? 6 : 7));
      end else begin
         c = c | (8'b1 << (4 + (j % 4)));
         c = c | (8'b1 << ((j < 8) ? 0 : 1));
         c = c | (8'b1 << (((j % 8) < 4) ? 2 : 3));
      end
      return c;
   endfunction

   inj_st_e     st_q, st_d;
   logic [39:0] mask_q, mask_d;

   logic        s1_v_q, s1_v_d, s1_en_q, s1_en_d, s1_inj_q, s1_inj_d;
   logic [31:0] s1_data_q, s1_data_d;
   logic [7:0]  s1_chk_q, s1_chk_d;

   logic        s2_v_q, s2_v_d, s2_en_q, s2_en_d, s2_inj_q, s2_inj_d;
   logic [31:0] s2_data_q, s2_data_d;
   logic [7:0]  s2_chk_q, s2_chk_d;

   logic             done_q, done_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic       in_fire, out_fire, s1_load, s2_load, arm_hit;
   logic [7:0] chk_c;

   // Handshake: S2 takes S1 whenever it is empty or draining; S1 refills
   // whenever it is empty or S2 is taking its word.
   assign s2_load  = ~s2_v_q | out_ready;
   assign s1_load  = ~s1_v_q | s2_load;
   assign in_ready = s1_load;
   assign in_fire  = in_valid & s1_load;
   assign out_fire = s2_v_q & out_ready;

   always_comb begin
      chk_c = '0;
      for (int k = 0; k < 32; k++) begin
         chk_c = chk_c ^ ({8{in_data[k]}} & col_of(k));
      end
   end

   // Injection FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q   <= IDLE;
         mask_q <= '0;
      end else begin
         st_q   <= st_d;
         mask_q <= mask_d;
      end
   end

   // Injection FSM: next state; requests while armed never overwrite the mask
   always_comb begin
      st_d   = st_q;
      mask_d = mask_q;
      unique case (st_q)
         IDLE: begin
            if (inj_req) begin
               st_d   = ARMED;
               mask_d = inj_mask;
            end
         end
         ARMED: begin
            if (in_fire) st_d = IDLE;
         end
         default: st_d = IDLE;
      endcase
   end

   // Injection FSM: output
   always_comb begin
      arm_hit = 1'b0;
      unique case (st_q)
         ARMED:   arm_hit = in_fire;
         default: arm_hit = 1'b0;
      endcase
   end

   always_comb begin
      s1_v_d    = s1_v_q;
      s1_data_d = s1_data_q;
      s1_chk_d  = s1_chk_q;
      s1_en_d   = s1_en_q;
      s1_inj_d  = s1_inj_q;
      if (s1_load) s1_v_d = in_fire;
      if (in_fire) begin
         s1_data_d = in_data ^ (arm_hit ? mask_q[31:0] : 32'h0);
         s1_chk_d  = chk_c ^ (arm_hit ? mask_q[39:32] : 8'h0);
         s1_en_d   = chk_en;
         s1_inj_d  = arm_hit;
      end
   end

   always_comb begin
      s2_v_d    = s2_v_q;
      s2_data_d = s2_data_q;
      s2_chk_d  = s2_chk_q;
      s2_en_d   = s2_en_q;
      s2_inj_d  = s2_inj_q;
      if (s2_load) begin
         s2_v_d = s1_v_q;
         if (s1_v_q) begin
            s2_data_d = s1_data_q;
            s2_chk_d  = s1_chk_q;
            s2_en_d   = s1_en_q;
            s2_inj_d  = s1_inj_q;
         end
      end
   end

   always_comb begin
      done_d = out_fire & s2_inj_q;
      cnt_d  = cnt_q;
      if (out_fire) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v_q    <= 1'b0;
         s1_data_q <= '0;
         s1_chk_q  <= '0;
         s1_en_q   <= 1'b0;
         s1_inj_q  <= 1'b0;
         s2_v_q    <= 1'b0;
         s2_data_q <= '0;
         s2_chk_q  <= '0;
         s2_en_q   <= 1'b0;
         s2_inj_q  <= 1'b0;
         done_q    <= 1'b0;
         cnt_q     <= '0;
      end else begin
         s1_v_q    <= s1_v_d;
         s1_data_q <= s1_data_d;
         s1_chk_q  <= s1_chk_d;
         s1_en_q   <= s1_en_d;
         s1_inj_q  <= s1_inj_d;
         s2_v_q    <= s2_v_d;
         s2_data_q <= s2_data_d;
         s2_chk_q  <= s2_chk_d;
         s2_en_q   <= s2_en_d;
         s2_inj_q  <= s2_inj_d;
         done_q    <= done_d;
         cnt_q     <= cnt_d;
      end
   end

   assign out_valid  = s2_v_q;
   assign out_data   = s2_data_q;
   assign out_check  = s2_chk_q;
   assign out_en     = s2_en_q;
   assign inj_done   = done_q;
   assign word_count = cnt_q;

endmodule

// File: tb/tb_sec32_encoder_pipe.sv
// Bench for sec32_encoder_pipe: check-bit table, scoreboard with an injection
// model and a syndrome decoder, backpressure, reset and random streaming.
module tb_sec32_encoder_pipe;
   localparam int CNT_W = 4;

   logic             clk = 1'b0, rst_n = 1'b0;
   logic             in_valid = 1'b0, in_ready, chk_en = 1'b0, inj_req = 1'b0;
   logic [31:0]      in_data = '0;
   logic [39:0]      inj_mask = '0;
   logic             out_valid, out_ready = 1'b0, out_en, inj_done;
   logic [31:0]      out_data;
   logic [7:0]       out_check;
   logic [CNT_W-1:0] word_count;

   sec32_encoder_pipe #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .chk_en(chk_en), .inj_req(inj_req), .inj_mask(inj_mask),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_check(out_check), .out_en(out_en), .inj_done(inj_done),
      .word_count(word_count)
   );

   always #5 clk = ~clk;

   typedef struct {logic [31:0] d; logic [7:0] c;} vec_t;
   typedef struct {logic [31:0] d; logic [7:0] c; logic en; logic inj; logic [31:0] od;} exp_t;

   exp_t             sbq[$];
   int               n_chk = 0, n_err = 0;
   int               ncyc = 0, n_done = 0, n_acc = 0;
   int               first_acc = -1, first_ov = -1;
   logic             m_armed = 1'b0, exp_done = 1'b0;
   logic [39:0]      m_mask = '0;
   logic [CNT_W-1:0] m_cnt = '0;
   logic             hold_v = 1'b0, hold_e = 1'b0;
   logic [31:0]      hold_d = '0;
   logic [7:0]       hold_c = '0;
   logic             ovr_v = 1'b0;
   logic [7:0]       ovr_c = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] enc(input logic [31:0] d);
      logic [7:0] c;
      c[0] = ^d[23:16] ^ d[0] ^ d[4] ^ d[8]  ^ d[12];
      c[1] = ^d[31:24] ^ d[1] ^ d[5] ^ d[9]  ^ d[13];
      c[2] = ^d[19:16] ^ ^d[27:24] ^ d[2] ^ d[6] ^ d[10] ^ d[14];
      c[3] = ^d[23:20] ^ ^d[31:28] ^ d[3] ^ d[7] ^ d[11] ^ d[15];
      c[4] = ^d[7:0]   ^ d[16] ^ d[20] ^ d[24] ^ d[28];
      c[5] = ^d[15:8]  ^ d[17] ^ d[21] ^ d[25] ^ d[29];
      c[6] = ^d[3:0]   ^ ^d[11:8]  ^ d[18] ^ d[22] ^ d[26] ^ d[30];
      c[7] = ^d[7:4]   ^ ^d[15:12] ^ d[19] ^ d[23] ^ d[27] ^ d[31];
      return c;
   endfunction

   // Golden corrector: flip the data bit whose own check signature equals the syndrome
   function automatic logic [31:0] dec(input logic [31:0] d, input logic [7:0] c);
      logic [7:0]  s;
      logic [31:0] r, one;
      s   = enc(d) ^ c;
      r   = d;
      one = 32'h1;
      if (s != 8'h0)
         for (int k = 0; k < 32; k++)
            if (enc(one << k) == s) r[k] = ~r[k];
      return r;
   endfunction

   task automatic model_reset();
      sbq.delete();
      m_armed  = 1'b0;
      m_mask   = '0;
      m_cnt    = '0;
      exp_done = 1'b0;
      hold_v   = 1'b0;
   endtask

   task automatic tick();
      exp_t e;
      @(negedge clk);
      ncyc++;
      chk("inj_done", {63'h0, inj_done}, {63'h0, exp_done});
      if (inj_done) n_done++;
      exp_done = 1'b0;
      chk("word_count", {60'h0, word_count}, {60'h0, m_cnt});
      if (hold_v) begin
         chk("hold_valid", {63'h0, out_valid}, 64'h1);
         chk("hold_data", {32'h0, out_data}, {32'h0, hold_d});
         chk("hold_check", {56'h0, out_check}, {56'h0, hold_c});
         chk("hold_en", {63'h0, out_en}, {63'h0, hold_e});
      end
      hold_v = out_valid & ~out_ready;
      hold_d = out_data;
      hold_c = out_check;
      hold_e = out_en;
      if (first_ov < 0 && out_valid) first_ov = ncyc;
      if (out_valid && out_ready) begin
         if (sbq.size() == 0) begin
            chk("spurious_out", 64'h1, 64'h0);
         end else begin
            e = sbq.pop_front();
            chk("out_data", {32'h0, out_data}, {32'h0, e.d});
            chk("out_check", {56'h0, out_check}, {56'h0, e.c});
            chk("out_en", {63'h0, out_en}, {63'h0, e.en});
            if (e.en) chk("decoded", {32'h0, dec(out_data, out_check)}, {32'h0, e.od});
            exp_done = e.inj;
         end
         m_cnt = m_cnt + 1'b1;
      end
      if (in_valid && in_ready) begin
         n_acc++;
         if (first_acc < 0) first_acc = ncyc;
         e.od  = in_data;
         e.d   = in_data;
         e.c   = ovr_v ? ovr_c : enc(in_data);
         e.en  = chk_en;
         e.inj = 1'b0;
         if (m_armed) begin
            e.d     = e.d ^ m_mask[31:0];
            e.c     = e.c ^ m_mask[39:32];
            e.inj   = 1'b1;
            m_armed = 1'b0;
         end else if (inj_req) begin
            m_armed = 1'b1;
            m_mask  = inj_mask;
         end
         sbq.push_back(e);
      end else if (!m_armed && inj_req) begin
         m_armed = 1'b1;
         m_mask  = inj_mask;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string nm);
      in_valid  = 1'b0;
      inj_req   = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20 && (sbq.size() != 0 || out_valid); i++) tick();
      tick();
      chk(nm, sbq.size(), 0);
   endtask

   vec_t tbl[6];
   int   acc0, done0;

   initial begin
      tbl[0] = '{32'h00000000, 8'h00};
      tbl[1] = '{32'h00000001, 8'h51};
      tbl[2] = '{32'h80000000, 8'h8A};
      tbl[3] = '{32'hFFFFFFFF, 8'h00};
      tbl[4] = '{32'h00000003, 8'h03};
      tbl[5] = '{32'h00010000, 8'h15};

      #13;
      chk("rst_in_ready", {63'h0, in_ready}, 64'h1);
      chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
      chk("rst_out_data", {32'h0, out_data}, 64'h0);
      chk("rst_out_check", {56'h0, out_check}, 64'h0);
      chk("rst_out_en", {63'h0, out_en}, 64'h0);
      chk("rst_inj_done", {63'h0, inj_done}, 64'h0);
      chk("rst_word_count", {60'h0, word_count}, 64'h0);
      #10 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Table of known check values, streamed back to back
      out_ready = 1'b1;
      chk_en    = 1'b1;
      in_valid  = 1'b1;
      ovr_v     = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_data = tbl[i].d;
         ovr_c   = tbl[i].c;
         tick();
      end
      ovr_v = 1'b0;
      drain("table_drain");
      chk("latency", first_ov - first_acc, 2);
      chk("count_after_table", {60'h0, word_count}, 64'd6 % (1 << CNT_W));

      // Data-bit injection, then coincident-request and leaving-armed cases
      done0    = n_done;
      inj_req  = 1'b1;
      inj_mask = 40'h00_00000001;
      tick();
      inj_req  = 1'b0;
      in_valid = 1'b1;
      in_data  = 32'h12345678;
      tick();
      in_data  = 32'h0BADF00D;
      tick();
      inj_req  = 1'b1;
      inj_mask = 40'h00_80000000;
      in_data  = 32'hCAFEF00D;
      tick();
      inj_req  = 1'b1;
      inj_mask = 40'h00_00010000;
      in_data  = 32'h13579BDF;
      tick();
      inj_req  = 1'b0;
      in_data  = 32'h2468ACE0;
      tick();
      drain("inj1_drain");
      chk("inj1_done_pulses", n_done - done0, 2);

      // Second request while armed is ignored
      done0    = n_done;
      inj_req  = 1'b1;
      inj_mask = 40'h01_00000000;
      tick();
      inj_mask = 40'hFF_00000000;
      tick();
      inj_req  = 1'b0;
      in_valid = 1'b1;
      in_data  = 32'hDEADBEEF;
      tick();
      in_data  = 32'h01234567;
      tick();
      drain("inj2_drain");
      chk("inj2_done_pulses", n_done - done0, 1);

      // Backpressure: two words accepted, then stall
      acc0      = n_acc;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_data = 32'hA0000000 + i;
         tick();
      end
      chk("bp_accepts", n_acc - acc0, 2);
      chk("bp_in_ready", {63'h0, in_ready}, 64'h0);
      drain("bp_drain");

      // Asynchronous reset with both stages full and an injection armed
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = 32'h55AA0000 + i;
         tick();
      end
      in_valid = 1'b0;
      inj_req  = 1'b1;
      inj_mask = 40'h00_FFFFFFFF;
      tick();
      inj_req = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", {63'h0, out_valid}, 64'h0);
      chk("mid_rst_word_count", {60'h0, word_count}, 64'h0);
      chk("mid_rst_in_ready", {63'h0, in_ready}, 64'h1);
      model_reset();
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      done0     = n_done;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'hA5A5A5A5;
      tick();
      drain("post_rst_drain");
      chk("post_rst_no_inj", n_done - done0, 0);

      // Random streaming with random backpressure; count wraps repeatedly
      acc0 = n_acc;
      for (int i = 0; i < 5000 && (n_acc - acc0) < 1000; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0) && ((n_acc - acc0) < 1000);
         out_ready = ($urandom_range(0, 3) != 0);
         chk_en    = ($urandom_range(0, 7) != 0);
         in_data   = $urandom;
         tick();
      end
      chk("rand_accepts", n_acc - acc0, 1000);
      drain("rand_drain");

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
